bit_serial_adder: RTL
=====================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands, sampled only when start is accepted.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-007 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-008 The block SHALL have port cout, output, 1 bit: the carry-out.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; on acceptance the block SHALL load a, b and cin into shift and carry registers, clear the bit counter and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL add operand bit 0 of each shift register plus the carry register using a 1-bit full-adder equation (s = x^y^c, co = xy|xc|yc), processing LSB-first.
REQ-014 In each SHIFT cycle, both operand registers SHALL shift right by one, the sum bit SHALL enter sum at the MSB with sum shifted right, and co SHALL be stored in the carry register.
REQ-015 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; for a start sampled at edge 0, sum and cout SHALL be final from edge WIDTH.
REQ-016 busy SHALL be 1 exactly while the FSM is in SHIFT.
REQ-017 done SHALL be 1 exactly while the FSM is in DONE, for one cycle.
REQ-018 From DONE without a new start, the FSM SHALL return to IDLE.
REQ-019 The result SHALL satisfy {cout,sum} = a + b + cin with WIDTH+1-bit arithmetic; sum wraps modulo 2^WIDTH.
REQ-020 sum and cout SHALL hold their final values in DONE and IDLE until the next accepted start.
REQ-021 start asserted during SHIFT SHALL be ignored, with no effect on operands, result or timing.
REQ-022 start asserted in the DONE cycle SHALL be accepted; the next operation begins with no idle gap.
REQ-023 Changes on a, b and cin outside an accepted start SHALL not affect an operation in progress.

Reset
REQ-024 While rst is 1, the FSM SHALL be in IDLE immediately, with no clock required.
REQ-025 While rst is 1, sum, cout, busy, done, the shift registers, the carry register and the bit counter SHALL be 0.
REQ-026 rst asserted mid-operation SHALL abort it: no done pulse and no partial result retained.
REQ-027 After rst deasserts, the next accepted start SHALL produce a correct result.

Configuration
REQ-028 With macro BIT_SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf, 1 bit: two's-complement signed overflow.
REQ-029 With BIT_SERIAL_ADDER_OVF_EN defined, ovf SHALL equal the carry into bit WIDTH-1 XOR cout, captured on the final SHIFT cycle.
REQ-030 With BIT_SERIAL_ADDER_OVF_EN defined, ovf SHALL be valid and held on the same schedule as sum, and SHALL reset to 0.
REQ-031 With BIT_SERIAL_ADDER_OVF_EN undefined, neither the ovf port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-032 a=0x00, b=0x00, cin=0, start for 1 cycle -> busy high 8 cycles; done pulse at edge 8; sum=0x00, cout=0.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (wrap-around).
REQ-034 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; with the macro defined, ovf=1.
REQ-035 Start a=0x12, b=0x34, cin=0; at cycle 3 assert start with a=0xFF, b=0xFF -> second start ignored; sum=0x46, cout=0 at edge 8.
REQ-036 Assert rst at SHIFT cycle 4 -> all outputs 0 immediately, no done pulse; then a=0x0F, b=0x01, cin=1 -> sum=0x11, cout=0.
REQ-037 Assert start in the done cycle with a=0xAA, b=0x55, cin=1 -> no idle gap; busy high the next cycle; after 8 cycles sum=0x00, cout=1.

Source files
------------

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one operand bit per clock, WIDTH cycles per add.
// Define BIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_bit, co_bit, last_bit;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    co_bit   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        c_d   = co_bit;
        cnt_d = cnt_q + CNT_W'(1);
        // cout/ovf only move on the final bit so they hold the last result throughout
        if (last_bit) begin
          state_d = DONE;
          cout_d  = co_bit;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ co_bit;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
